// File: rtl/minutes_counter.sv
// Minutes stage of the digital clock: BCD time and alarm minutes, manual digit
// stepping, display selection, hour carry and alarm-hit pulses.
module minutes_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       minTick,
    input  logic       setSignal,
    input  logic       alarmSignal,
    input  logic       setLMSignal,
    input  logic       setRMSignal,
    output logic [3:0] rightMin,
    output logic [2:0] leftMin,
    output logic       hourCarry,
    output logic       alarmHit
);

    // Encoding matches {alarmSignal, setSignal} so the mode loads by a cast.
    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_LOCK      = 2'd3
    } mode_e;

    mode_e      mode_q, mode_d;
    logic [3:0] tr_q, tr_d, ar_q, ar_d, right_min_q, right_min_d;
    logic [2:0] tl_q, tl_d, al_q, al_d, left_min_q, left_min_d;
    logic       pl_q, pr_q;
    logic       hour_carry_q, hour_carry_d, alarm_hit_q, alarm_hit_d;
    logic       rise_l_s, rise_r_s, tick_adv_s, hit_mode_s;

    // Next-state: tick advance, button stepping, range guard, display select.
    always_comb begin
        mode_d       = mode_e'({alarmSignal, setSignal});
        rise_l_s     = setLMSignal & ~pl_q;
        rise_r_s     = setRMSignal & ~pr_q;
        tr_d         = tr_q;
        tl_d         = tl_q;
        ar_d         = ar_q;
        al_d         = al_q;
        hour_carry_d = 1'b0;
        alarm_hit_d  = 1'b0;
        tick_adv_s   = 1'b0;
        hit_mode_s   = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                tick_adv_s = minTick;
                hit_mode_s = 1'b1;
            end
            MODE_SET_TIME: begin
                tick_adv_s = 1'b0;
                hit_mode_s = 1'b0;
            end
            MODE_SET_ALARM: begin
                tick_adv_s = minTick;
                hit_mode_s = 1'b1;
            end
            MODE_LOCK: begin
                tick_adv_s = minTick;
                hit_mode_s = 1'b0;
            end
            default: begin
                tick_adv_s = 1'b0;
                hit_mode_s = 1'b0;
            end
        endcase

        if (tick_adv_s) begin
            if (tr_q == 4'd9) begin
                tr_d = 4'd0;
                if (tl_q == 3'd5) begin
                    tl_d         = 3'd0;
                    hour_carry_d = 1'b1;
                end else begin
                    tl_d = tl_q + 3'd1;
                end
            end else begin
                tr_d = tr_q + 4'd1;
            end
        end else if (mode_q == MODE_SET_TIME) begin
            // Manual steps wrap within one digit and never carry.
            if (rise_l_s) begin
                tl_d = (tl_q == 3'd5) ? 3'd0 : tl_q + 3'd1;
            end else if (rise_r_s) begin
                tr_d = (tr_q == 4'd9) ? 4'd0 : tr_q + 4'd1;
            end else begin
                tr_d = tr_q;
            end
        end else begin
            tr_d = tr_q;
        end

        if (mode_q == MODE_SET_ALARM) begin
            if (rise_l_s) begin
                al_d = (al_q == 3'd5) ? 3'd0 : al_q + 3'd1;
            end else if (rise_r_s) begin
                ar_d = (ar_q == 4'd9) ? 4'd0 : ar_q + 4'd1;
            end else begin
                ar_d = ar_q;
            end
        end else begin
            ar_d = ar_q;
        end

        // Corrupted digits are forced back to zero.
        if (tr_q > 4'd9) begin tr_d = 4'd0; end else begin tr_d = tr_d; end
        if (tl_q > 3'd5) begin tl_d = 3'd0; end else begin tl_d = tl_d; end
        if (ar_q > 4'd9) begin ar_d = 4'd0; end else begin ar_d = ar_d; end
        if (al_q > 3'd5) begin al_d = 3'd0; end else begin al_d = al_d; end

        if (tick_adv_s && hit_mode_s && (tr_d == ar_q) && (tl_d == al_q)) begin
            alarm_hit_d = 1'b1;
        end else begin
            alarm_hit_d = 1'b0;
        end

        if (mode_q == MODE_SET_ALARM) begin
            right_min_d = ar_d;
            left_min_d  = al_d;
        end else begin
            right_min_d = tr_d;
            left_min_d  = tl_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_RUN;
            tr_q         <= 4'd0;
            tl_q         <= 3'd0;
            ar_q         <= 4'd0;
            al_q         <= 3'd0;
            pl_q         <= 1'b1;
            pr_q         <= 1'b1;
            right_min_q  <= 4'd0;
            left_min_q   <= 3'd0;
            hour_carry_q <= 1'b0;
            alarm_hit_q  <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            tr_q         <= tr_d;
            tl_q         <= tl_d;
            ar_q         <= ar_d;
            al_q         <= al_d;
            pl_q         <= setLMSignal;
            pr_q         <= setRMSignal;
            right_min_q  <= right_min_d;
            left_min_q   <= left_min_d;
            hour_carry_q <= hour_carry_d;
            alarm_hit_q  <= alarm_hit_d;
        end
    end

    assign rightMin  = right_min_q;
    assign leftMin   = left_min_q;
    assign hourCarry = hour_carry_q;
    assign alarmHit  = alarm_hit_q;

endmodule

// File: tb/tb_minutes_counter.sv
// Scoreboard bench for minutes_counter: each cycle's expected outputs are queued
// with the stimulus and compared against the sampled outputs per scenario.
module tb_minutes_counter;

    typedef struct packed {
        logic [3:0] rm;
        logic [2:0] lm;
        logic       hc;
        logic       ah;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       minTick = 1'b0;
    logic       setSignal = 1'b0;
    logic       alarmSignal = 1'b0;
    logic       setLMSignal = 1'b0;
    logic       setRMSignal = 1'b0;
    logic [3:0] rightMin;
    logic [2:0] leftMin;
    logic       hourCarry;
    logic       alarmHit;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    minutes_counter dut (
        .clk(clk), .rst(rst), .minTick(minTick), .setSignal(setSignal),
        .alarmSignal(alarmSignal), .setLMSignal(setLMSignal), .setRMSignal(setRMSignal),
        .rightMin(rightMin), .leftMin(leftMin), .hourCarry(hourCarry), .alarmHit(alarmHit)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue its expectation, capture outputs after the edge.
    task automatic apply(input logic r_st, input logic tk, input logic s, input logic a,
                         input logic l, input logic r, input int erm, input int elm,
                         input logic ehc, input logic eah);
        obs_t e;
        rst = r_st; minTick = tk; setSignal = s; alarmSignal = a;
        setLMSignal = l; setRMSignal = r;
        e.rm = erm[3:0]; e.lm = elm[2:0]; e.hc = ehc; e.ah = eah;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back({rightMin, leftMin, hourCarry, alarmHit});
    endtask

    task automatic test_reset();
        obs_t e, o;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_run_count();
        obs_t e, o;
        for (int i = 1; i <= 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i % 10, i / 10, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i % 10, i / 10, 1'b0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_count got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1 + k, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1 + k, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 9; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, k, 5, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, k, 5, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 5, 1'b0, 1'b0);
        // Alarm is still 00, so the wrap to 00 also hits it.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_set_time_ignore();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            apply(1'b0, (i < 20), 1'b1, 1'b0, 1'b0, (i % 2 == 0), (i / 2 + 1) % 10, 0, 1'b0, 1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (j % 2 == 0), (2 + j / 2 + 1) % 10, 0, 1'b0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL set_time got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_alarm();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, k, 0, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k, 0, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i, 0, 1'b0, (i == 5));
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i, 0, 1'b0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alarm got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, k, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, k, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5 + k, 5, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5 + k, 5, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simultaneous got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_reset_hold();
        obs_t e, o;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, k, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, k, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1 + k, 3, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1 + k, 3, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 3, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 3, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_hold got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    task automatic test_lock();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lock got rm=%0d lm=%0d hc=%b ah=%b want rm=%0d lm=%0d hc=%b ah=%b",
                         o.rm, o.lm, o.hc, o.ah, e.rm, e.lm, e.hc, e.ah);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_wrap();
        test_set_time_ignore();
        test_alarm();
        test_simultaneous();
        test_reset_hold();
        test_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minutes_counter.md
# minutes_counter

Minutes timekeeping stage of the digital clock, placed directly upstream of the minutes display controller. Counts time minutes as a right BCD digit (0–9) and a left digit (0–5), advanced by a once-per-minute tick from the seconds stage. Supports manual setting of the time and alarm minutes, and drives the display digits, a carry pulse to the hours stage, and an alarm-hit pulse.

## Interface
No parameters.
- clk  in  1  system clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- minTick  in  1  one-cycle pulse from the seconds stage at each 59→00 seconds rollover
- setSignal  in  1  level; time-set mode request
- alarmSignal  in  1  level; alarm-set mode request
- setLMSignal  in  1  level, pre-synchronized; left-digit increment button
- setRMSignal  in  1  level, pre-synchronized; right-digit increment button
- rightMin  out  4  displayed right minute digit, 0–9
- leftMin  out  3  displayed left minute digit, 0–5
- hourCarry  out  1  one-cycle pulse when the time minutes wrap 59→00
- alarmHit  out  1  one-cycle pulse when a tick advance lands on the alarm minutes

## Operation
- State: time digits tR/tL, alarm digits aR/aL, registered mode, button history bits pL/pR, and output registers.
- The mode register loads every cycle from the inputs:
  - RUN: set=0, alarm=0.
  - SET_TIME: set=1, alarm=0.
  - SET_ALARM: set=0, alarm=1.
  - LOCK: set=1, alarm=1.
- Every action at an edge uses the mode value held *before* that edge. This gives a one-cycle mode latency.
- Tick handling:
  - In RUN, SET_ALARM and LOCK: minTick advances the time. tR increments. When tR=9, tR→0 and tL increments. When tL=5 and tR=9, both go to 0 and hourCarry fires.
  - In SET_TIME: minTick is ignored, the time is frozen, and hourCarry stays 0.
- Button edges: riseL = setLMSignal & ~pL, and riseR = setRMSignal & ~pR. pL and pR load the inputs every cycle.
- Button actions by mode:
  - SET_TIME: riseL steps tL (5→0) and riseR steps tR (9→0). A digit step never carries into the other digit and never fires hourCarry.
  - SET_ALARM: the same stepping applies to aL and aR.
  - RUN and LOCK: edges are ignored, but pL and pR still update.
  - If riseL and riseR occur in the same cycle, only the left digit steps.
- Combined events in SET_ALARM: a tick advance (time) and a button step (alarm) in the same cycle both apply.
- alarmHit fires when a tick advance in RUN or SET_ALARM produces next-time == alarm. It never fires in LOCK, in SET_TIME, or from a manual step.
- Display selection: shows aR/aL when the mode is SET_ALARM, otherwise tR/tL.
- Range guard: any digit found out of range (tR>9, tL>5, or the same for the alarm digits) loads 0 on the next edge.

## Timing
- Reset values: tR=tL=aR=aL=0, mode=RUN, pL=pR=1 (a button held through reset does not step a digit), rightMin=0, leftMin=0, hourCarry=0, alarmHit=0.
- rst overrides every other input on the same edge, including during any mode or while a tick is pending.
- Tick latency: minTick high at edge k gives updated digits on rightMin/leftMin after edge k. hourCarry and alarmHit are high only for the cycle following edge k.
- Button latency: a button sampled high at edge k with its history bit 0 steps the digit at edge k. The output shows the new value after edge k.
- Mode change latency: inputs change before edge k, the mode register updates at edge k, and the new behaviour applies from edge k+1. A minTick at edge k still follows the old mode.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset, then 10 minTicks in RUN: rightMin goes 1..9 then 0, and leftMin=1 after the 10th tick. hourCarry stays 0.
- Preload 59 via SET_TIME, return to RUN, then one minTick: the outputs read 00, and hourCarry is high for exactly one cycle.
- In SET_TIME, hold minTick for 20 pulses and press setRMSignal 12 times: the time reads 02, the ticks are ignored, and hourCarry is never asserted.
- Set the alarm to 05 in SET_ALARM: the display shows 05 during SET_ALARM. Return to RUN from 00 and apply 5 minTicks: alarmHit pulses once, on the 5th tick.
- Assert setLMSignal and setRMSignal rising together in SET_ALARM with the alarm at 59: the alarm reads 09 (left wraps 5→0, right unchanged).
- Hold setRMSignal through reset and release reset in SET_TIME: no step occurs. Assert rst mid-count at 37: all outputs read 0 on the next cycle.
